// File: rtl/user_segn_pkg.sv
// rtl/user_segn_pkg.sv - Register map, bit positions and hex-decode table for user_segn_avalon
package user_segn_pkg;

  localparam logic [4:0] DIGIT_BASE  = 5'd0;
  localparam logic [4:0] CTRL_ADDR   = 5'd16;
  localparam logic [4:0] STATUS_ADDR = 5'd17;

  localparam int DIGIT_W = 10;

  // DIGIT[k] fields
  localparam int RAW   = 7;
  localparam int BLINK = 8;
  localparam int BLANK = 9;

  // CTRL fields
  localparam int EN     = 8;
  localparam int COMMIT = 9;

  typedef logic [DIGIT_W-1:0] digit_reg_t;

  // Active-high a..g patterns, entry i is the glyph for hex digit i
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/user_segn_avalon_if.sv
// rtl/user_segn_avalon_if.sv - Avalon-MM slave port bundle for user_segn_avalon
interface user_segn_avalon_if;

  logic [4:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - Combinational 4-bit hex to active-high seven-segment decoder
module seg7_hex_decode
  import user_segn_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/user_segn_avalon.sv
// rtl/user_segn_avalon.sv - Avalon-MM seven-segment driver with shadowed digits, PWM brightness and blink
module user_segn_avalon
  import user_segn_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  user_segn_avalon_if.slave       avs,
  output logic [7*NUM_DIGITS-1:0] seg_o
);

  localparam int                  BCW        = $clog2(BLINK_DIV);
  localparam logic [BCW-1:0]      BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [6:0]          SEG_POL    = {7{ACTIVE_LOW}};

  digit_reg_t            shadow_q [NUM_DIGITS];
  digit_reg_t            shadow_d [NUM_DIGITS];
  digit_reg_t            active_q [NUM_DIGITS];
  digit_reg_t            active_d [NUM_DIGITS];
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic                  en_q, en_d;
  logic                  commit_pend_q, commit_pend_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BCW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [6:0]            hex_seg [NUM_DIGITS];

  logic wr_ctrl;
  logic do_copy;
  logic pwm_on;
  logic unused_wdata;

  assign wr_ctrl      = avs.avs_write && (avs.avs_address == CTRL_ADDR);
  assign do_copy      = commit_pend_q && (pwm_cnt_q == PWM_MAX);
  assign pwm_on       = (bright_q == PWM_MAX) || (pwm_cnt_q < bright_q);
  assign unused_wdata = ^avs.avs_writedata;

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : gen_hex
      seg7_hex_decode u_hex (
        .hex_i (active_q[k][3:0]),
        .seg_o (hex_seg[k])
      );
    end
  endgenerate

  // Shadow write lands before the copy so a same-cycle digit write is committed too
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      shadow_d[k] = shadow_q[k];
      if (avs.avs_write && (avs.avs_address == DIGIT_BASE + 5'(k))) begin
        shadow_d[k] = avs.avs_writedata[DIGIT_W-1:0];
      end
      active_d[k] = do_copy ? shadow_d[k] : active_q[k];
    end

    bright_d = bright_q;
    en_d     = en_q;
    if (wr_ctrl) begin
      bright_d = avs.avs_writedata[PWM_BITS-1:0];
      en_d     = avs.avs_writedata[EN];
    end

    commit_pend_d = commit_pend_q && !do_copy;
    if (wr_ctrl && avs.avs_writedata[COMMIT]) begin
      commit_pend_d = 1'b1;
    end

    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    blink_cnt_d = blink_cnt_q + BCW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = !phase_q;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (avs.avs_read) begin
      readdata_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (avs.avs_address == DIGIT_BASE + 5'(k)) begin
          readdata_d[DIGIT_W-1:0] = shadow_q[k];
        end
      end
      if (avs.avs_address == CTRL_ADDR) begin
        readdata_d[PWM_BITS-1:0] = bright_q;
        readdata_d[EN]           = en_q;
        readdata_d[COMMIT]       = commit_pend_q;
      end
      if (avs.avs_address == STATUS_ADDR) begin
        readdata_d[1:0] = {commit_pend_q, phase_q};
      end
    end
  end

  always_comb begin
    seg_d = {NUM_DIGITS{SEG_POL}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (en_q && pwm_on && !active_q[k][BLANK] && !(active_q[k][BLINK] && phase_q)) begin
        seg_d[7*k +: 7] = (active_q[k][RAW] ? active_q[k][6:0] : hex_seg[k]) ^ SEG_POL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      bright_q      <= '0;
      en_q          <= 1'b0;
      commit_pend_q <= 1'b0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      readdata_q    <= '0;
      seg_q         <= {NUM_DIGITS{SEG_POL}};
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      bright_q      <= bright_d;
      en_q          <= en_d;
      commit_pend_q <= commit_pend_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      readdata_q    <= readdata_d;
      seg_q         <= seg_d;
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign seg_o            = seg_q;

endmodule

// File: tb/tb_user_segn_avalon.sv
// tb/tb_user_segn_avalon.sv - Self-checking bench for user_segn_avalon against a cycle-count reference model
module tb_user_segn_avalon;

  localparam int ND   = 8;
  localparam int PB   = 4;
  localparam int BDIV = 10;
  localparam logic [55:0] ALL_OFF = {56{1'b1}};
  localparam logic [55:0] ALL_ZERO_GLYPH = {8{7'h40}};

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [55:0] seg;
  int          checks = 0;
  int          errors = 0;
  int          n = 0;

  user_segn_avalon_if avs_if ();

  user_segn_avalon #(
    .NUM_DIGITS (ND),
    .PWM_BITS   (PB),
    .BLINK_DIV  (BDIV),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .avs   (avs_if),
    .seg_o (seg)
  );

  always #5 clk = ~clk;

  logic [9:0]  m_shadow [ND];
  logic [9:0]  m_active [ND];
  logic [3:0]  m_bright;
  logic        m_en;
  logic        m_pend;
  logic [31:0] m_rd;
  logic [55:0] m_seg;
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_bright = '0;
    m_en     = 1'b0;
    m_pend   = 1'b0;
    m_rd     = '0;
    m_seg    = ALL_OFF;
    n        = 0;
  endtask

  function automatic logic [55:0] model_seg(input int pwm, input bit ph);
    logic [55:0] s;
    logic [6:0]  p;
    bit          on;
    on = (m_bright == 4'hF) || (pwm < int'(m_bright));
    for (int k = 0; k < ND; k++) begin
      p = m_active[k][7] ? m_active[k][6:0] : hex_tab[m_active[k][3:0]];
      if (m_en && on && !m_active[k][9] && !(m_active[k][8] && ph)) s[7*k +: 7] = ~p;
      else s[7*k +: 7] = 7'h7F;
    end
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr, input bit ph);
    logic [31:0] r;
    r = '0;
    if (int'(addr) < ND) r[9:0] = m_shadow[addr[2:0]];
    else if (addr == 5'd16) begin
      r[3:0] = m_bright;
      r[8]   = m_en;
      r[9]   = m_pend;
    end else if (addr == 5'd17) r[1:0] = {m_pend, ph};
    return r;
  endfunction

  // Counter states are derived from the number of edges since reset release
  task automatic step(input bit wr, input logic [4:0] addr, input logic [31:0] wd, input bit rd);
    int pwm;
    bit ph;
    avs_if.avs_write     = wr;
    avs_if.avs_read      = rd;
    avs_if.avs_address   = addr;
    avs_if.avs_writedata = wd;
    pwm = n % 16;
    ph  = ((n / BDIV) % 2) == 1;
    m_seg = model_seg(pwm, ph);
    if (rd) m_rd = model_read(addr, ph);
    if (wr && int'(addr) < ND) m_shadow[addr[2:0]] = wd[9:0];
    if (wr && addr == 5'd16) begin
      m_bright = wd[3:0];
      m_en     = wd[8];
    end
    if (pwm == 15 && m_pend) begin
      for (int k = 0; k < ND; k++) m_active[k] = m_shadow[k];
      m_pend = 1'b0;
    end
    if (wr && addr == 5'd16 && wd[9]) m_pend = 1'b1;
    @(posedge clk);
    n++;
    #1;
    avs_if.avs_write = 1'b0;
    avs_if.avs_read  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
    step(1'b1, addr, wd, 1'b0);
  endtask

  task automatic rd(input logic [4:0] addr);
    step(1'b0, addr, 32'h0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic align_to_wrap();
    for (int i = 0; i < 16 && (n % 16) != 15; i++) idle();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (seg !== ALL_OFF) begin errors++; $display("FAIL reset_seg got=%h exp=%h", seg, ALL_OFF); end
    checks++;
    if (avs_if.avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", avs_if.avs_readdata); end
    reset = 1'b0;
    model_reset();
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", avs_if.avs_readdata); end
    checks++;
    if (seg !== ALL_OFF) begin errors++; $display("FAIL reset_seg_dark got=%h exp=%h", seg, ALL_OFF); end
  endtask

  task automatic test_commit();
    int first_lit;
    first_lit = -1;
    wr(5'd0, 32'h3);
    wr(5'd16, 32'h10F);
    wr(5'd16, 32'h30F);
    for (int i = 0; i < 18; i++) begin
      idle();
      checks++;
      if (seg !== m_seg) begin errors++; $display("FAIL commit_seg n=%0d got=%h exp=%h", n, seg, m_seg); end
      if (first_lit < 0 && seg[6:0] == 7'h30) first_lit = i + 1;
    end
    checks++;
    if (first_lit < 1 || first_lit > 17) begin errors++; $display("FAIL commit_latency got=%0d exp=1..17", first_lit); end
    checks++;
    if (seg[6:0] !== 7'h30) begin errors++; $display("FAIL commit_digit0 got=%h exp=30", seg[6:0]); end
    checks++;
    if (seg[55:7] !== {7{7'h40}}) begin errors++; $display("FAIL commit_others got=%h exp=%h", seg[55:7], {7{7'h40}}); end
  endtask

  task automatic test_shadow_hold();
    logic [55:0] s0;
    bit changed;
    s0 = seg;
    changed = 1'b0;
    wr(5'd2, 32'h0C9);
    for (int i = 0; i < 100; i++) begin
      idle();
      if (seg !== s0) changed = 1'b1;
      checks++;
      if (seg !== m_seg) begin errors++; $display("FAIL hold_seg n=%0d got=%h exp=%h", n, seg, m_seg); end
    end
    checks++;
    if (changed) begin errors++; $display("FAIL hold_unchanged got=1 exp=0"); end
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata[31:1] !== 31'h0) begin errors++; $display("FAIL hold_status got=%h exp=0 (phase ignored)", avs_if.avs_readdata); end
    rd(5'd2);
    checks++;
    if (avs_if.avs_readdata !== 32'h0C9) begin errors++; $display("FAIL hold_readback got=%h exp=0c9", avs_if.avs_readdata); end
    wr(5'd16, 32'h30F);
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata[1] !== 1'b1) begin errors++; $display("FAIL hold_pending got=%b exp=1", avs_if.avs_readdata[1]); end
    for (int i = 0; i < 17; i++) idle();
    checks++;
    if (seg[20:14] !== 7'h36) begin errors++; $display("FAIL hold_digit2 got=%h exp=36", seg[20:14]); end
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata[1] !== 1'b0) begin errors++; $display("FAIL hold_pend_clear got=%b exp=0", avs_if.avs_readdata[1]); end
  endtask

  task automatic pwm_run(input logic [31:0] ctrl, input int exp_lit);
    int lit;
    lit = 0;
    wr(5'd16, ctrl);
    idle();
    for (int i = 0; i < 32; i++) begin
      idle();
      if (seg[6:0] != 7'h7F) lit++;
      checks++;
      if (seg !== m_seg) begin errors++; $display("FAIL pwm_seg n=%0d got=%h exp=%h", n, seg, m_seg); end
    end
    checks++;
    if (lit != exp_lit) begin errors++; $display("FAIL pwm_duty ctrl=%h got=%0d exp=%0d", ctrl, lit, exp_lit); end
  endtask

  task automatic test_pwm();
    pwm_run(32'h104, 8);
    pwm_run(32'h10F, 32);
    pwm_run(32'h100, 0);
  endtask

  task automatic test_blink();
    int lit0, lit1;
    lit0 = 0;
    lit1 = 0;
    wr(5'd1, 32'h101);
    wr(5'd16, 32'h30F);
    for (int i = 0; i < 18; i++) idle();
    for (int i = 0; i < 40; i++) begin
      idle();
      if (seg[6:0] != 7'h7F) lit0++;
      if (seg[13:7] != 7'h7F) lit1++;
      checks++;
      if (seg !== m_seg) begin errors++; $display("FAIL blink_seg n=%0d got=%h exp=%h", n, seg, m_seg); end
    end
    checks++;
    if (lit1 != 20) begin errors++; $display("FAIL blink_digit1 got=%0d exp=20", lit1); end
    checks++;
    if (lit0 != 40) begin errors++; $display("FAIL blink_digit0 got=%0d exp=40", lit0); end
  endtask

  task automatic test_wrap_commit();
    wr(5'd16, 32'h30F);
    align_to_wrap();
    wr(5'd3, 32'h0F5);
    idle();
    checks++;
    if (seg[27:21] !== 7'h0A) begin errors++; $display("FAIL wrap_digit3 got=%h exp=0a", seg[27:21]); end
    checks++;
    if (seg !== m_seg) begin errors++; $display("FAIL wrap_seg got=%h exp=%h", seg, m_seg); end
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata[1] !== 1'b0) begin errors++; $display("FAIL wrap_pend_clear got=%b exp=0", avs_if.avs_readdata[1]); end
    wr(5'd16, 32'h30F);
    align_to_wrap();
    wr(5'd16, 32'h30F);
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata[1] !== 1'b1) begin errors++; $display("FAIL wrap_pend_kept got=%b exp=1", avs_if.avs_readdata[1]); end
    for (int i = 0; i < 16; i++) idle();
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata[1] !== 1'b0) begin errors++; $display("FAIL wrap_second_copy got=%b exp=0", avs_if.avs_readdata[1]); end
    wr(5'd9, 32'hFFFF_FFFF);
    wr(5'd20, 32'hFFFF_FFFF);
    rd(5'd9);
    checks++;
    if (avs_if.avs_readdata !== 32'h0) begin errors++; $display("FAIL unmapped_9 got=%h exp=0", avs_if.avs_readdata); end
    rd(5'd20);
    checks++;
    if (avs_if.avs_readdata !== 32'h0) begin errors++; $display("FAIL unmapped_20 got=%h exp=0", avs_if.avs_readdata); end
    checks++;
    if (seg !== m_seg) begin errors++; $display("FAIL unmapped_seg got=%h exp=%h", seg, m_seg); end
  endtask

  task automatic test_random();
    int sel;
    logic [4:0] addr;
    bit do_wr, do_rd;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 11));
      if (sel < 8) addr = 5'(sel);
      else if (sel == 8) addr = 5'd16;
      else if (sel == 9) addr = 5'd17;
      else addr = 5'($urandom_range(0, 31));
      do_wr = ($urandom_range(0, 2) == 0);
      do_rd = ($urandom_range(0, 1) == 0);
      step(do_wr, addr, $urandom, do_rd);
      checks++;
      if (seg !== m_seg) begin errors++; $display("FAIL rand_seg n=%0d got=%h exp=%h", n, seg, m_seg); end
      checks++;
      if (avs_if.avs_readdata !== m_rd) begin errors++; $display("FAIL rand_rdata n=%0d addr=%0d got=%h exp=%h", n, addr, avs_if.avs_readdata, m_rd); end
    end
  endtask

  task automatic test_reset_pending();
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 16 && (n % 16) != 0; i++) idle();
    wr(5'd16, 32'h30F);
    idle();
    idle();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (seg !== ALL_OFF) begin errors++; $display("FAIL rstmid_seg got=%h exp=%h", seg, ALL_OFF); end
    checks++;
    if (avs_if.avs_readdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", avs_if.avs_readdata); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    wr(5'd16, 32'h10F);
    wr(5'd0, 32'h008);
    for (int i = 0; i < 40; i++) begin
      if (seg !== ALL_ZERO_GLYPH) bad = 1'b1;
      checks++;
      if (seg !== m_seg) begin errors++; $display("FAIL rstmid_model n=%0d got=%h exp=%h", n, seg, m_seg); end
      idle();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_no_commit got=changed exp=%h", ALL_ZERO_GLYPH); end
    rd(5'd17);
    checks++;
    if (avs_if.avs_readdata[1] !== 1'b0) begin errors++; $display("FAIL rstmid_pend got=%b exp=0", avs_if.avs_readdata[1]); end
  endtask

  initial begin
    avs_if.avs_address   = '0;
    avs_if.avs_write     = 1'b0;
    avs_if.avs_writedata = '0;
    avs_if.avs_read      = 1'b0;
    model_reset();
    test_reset();
    test_commit();
    test_shadow_hold();
    test_pwm();
    test_blink();
    test_wrap_commit();
    test_random();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
